// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer state encoding, default widths and response status.
// Used by both the requester (apb_master) and the completer (apb_slave).
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_t;

   typedef enum logic {
      APB_OK      = 1'b0,
      APB_TIMEOUT = 1'b1
   } apb_status_t;

   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int DEFAULT_ADDR_WIDTH = 4;
   localparam int DEFAULT_TIMEOUT    = 15;

   // Wait counter must hold 0..timeout; timeout is limited to 255, so this never exceeds 8.
   function automatic int cnt_width(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles with PREADY low; expired flags the cycle that is the
// TIMEOUT-th consecutive wait state, so the caller can abort on that edge.
module apb_wait_timer
   import apb_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int            CW   = cnt_width(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] count;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + CW'(1);
      end
   end

   assign expired = en && (count == LAST);

endmodule

// File: rtl/apb_master.sv
// APB requester: takes one command at a time on a valid/ready port, runs it as a
// SETUP/ACCESS transfer, and returns data/status on a one-cycle response strobe.
module apb_master
   import apb_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  PSELx,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PREADY
);

   apb_state_t  state, next_state;
   apb_status_t status;
   logic        accept;
   logic        timer_clr;
   logic        timer_en;
   logic        expired;

   // cmd_ready is low in the first cycle after reset even though state is IDLE.
   assign accept    = (state == IDLE) && cmd_ready && cmd_valid;
   assign timer_clr = (state == SETUP);
   assign timer_en  = (state == ACCESS) && !PREADY;

   apb_wait_timer #(
      .TIMEOUT(TIMEOUT)
   ) u_wait_timer (
      .clk    (PCLK),
      .rst    (PRESET),
      .clr    (timer_clr),
      .en     (timer_en),
      .expired(expired)
   );

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // NOTE: every signal written here gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      next_state = state;
      status     = APB_OK;
      unique case (state)
         IDLE: begin
            if (accept) next_state = SETUP;
         end
         SETUP: begin
            next_state = ACCESS;
         end
         ACCESS: begin
            // A ready slave wins over a timeout landing in the same cycle.
            if (PREADY) begin
               next_state = IDLE;
            end else if (expired) begin
               next_state = IDLE;
               status     = APB_TIMEOUT;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Outputs are registered from next_state so they line up with the state they describe.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         PSELx     <= 1'b0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
      end else begin
         cmd_ready <= (next_state == IDLE);
         PSELx     <= (next_state != IDLE);
         PENABLE   <= (next_state == ACCESS);
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         if (accept) begin
            PWRITE <= cmd_write;
            PADDR  <= cmd_addr;
            PWDATA <= cmd_wdata;
         end
         if ((state == ACCESS) && (next_state == IDLE)) begin
            rsp_valid <= 1'b1;
            rsp_err   <= (status == APB_TIMEOUT);
            if ((status == APB_OK) && !PWRITE) rsp_rdata <= PRDATA;
         end
      end
   end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: a timeline model of each transfer plus a
// shadow memory standing in for the slave, with randomized commands and wait states.
module tb_apb_master;

   localparam int TO = 4;

   logic       PCLK = 1'b0;
   logic       PRESET;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_write;
   logic [3:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic       PSELx;
   logic       PENABLE;
   logic       PWRITE;
   logic [3:0] PADDR;
   logic [7:0] PWDATA;
   logic [7:0] PRDATA;
   logic       PREADY;

   logic [7:0] mem [16];
   logic [3:0] last_addr;
   int         total = 0;
   int         bad   = 0;

   apb_master #(
      .DATA_WIDTH(8),
      .ADDR_WIDTH(4),
      .TIMEOUT   (TO)
   ) dut (
      .PCLK     (PCLK),
      .PRESET   (PRESET),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_write(cmd_write),
      .cmd_addr (cmd_addr),
      .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .rsp_err  (rsp_err),
      .PSELx    (PSELx),
      .PENABLE  (PENABLE),
      .PWRITE   (PWRITE),
      .PADDR    (PADDR),
      .PWDATA   (PWDATA),
      .PRDATA   (PRDATA),
      .PREADY   (PREADY)
   );

   always #5 PCLK = ~PCLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic rand_inputs();
      cmd_valid = 1'($urandom);
      cmd_write = 1'($urandom);
      cmd_addr  = 4'($urandom);
      cmd_wdata = 8'($urandom);
      PRDATA    = 8'($urandom);
      PREADY    = 1'($urandom);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, ".cmd_ready"}, cmd_ready, 0);
      check({tag, ".rsp_valid"}, rsp_valid, 0);
      check({tag, ".rsp_rdata"}, rsp_rdata, 0);
      check({tag, ".rsp_err"},   rsp_err,   0);
      check({tag, ".psel"},      PSELx,     0);
      check({tag, ".penable"},   PENABLE,   0);
      check({tag, ".pwrite"},    PWRITE,    0);
      check({tag, ".paddr"},     PADDR,     0);
      check({tag, ".pwdata"},    PWDATA,    0);
   endtask

   // n idle cycles: no command, bus quiet, address holds its last value.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge PCLK);
         check("idle.cmd_ready", cmd_ready, 1);
         check("idle.psel",      PSELx,     0);
         check("idle.penable",   PENABLE,   0);
         check("idle.rsp_valid", rsp_valid, 0);
         check("idle.paddr",     PADDR,     last_addr);
         rand_inputs();
         cmd_valid = 1'b0;
      end
   endtask

   // One transfer with 'waits' PREADY-low ACCESS cycles. Entered at a negedge
   // where cmd_ready is expected high; returns at the negedge of the response cycle.
   task automatic xfer(input logic wr, input logic [3:0] addr, input logic [7:0] wdata,
                       input int waits, input bit hold);
      bit         ok;
      int         lat;
      logic [7:0] exp_rd;
      ok     = (waits < TO);
      lat    = ok ? waits + 3 : TO + 2;
      exp_rd = (ok && !wr) ? mem[addr] : 8'h00;
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      check("accept.cmd_ready", cmd_ready, 1);
      @(posedge PCLK);
      for (int c = 1; c <= lat; c++) begin
         @(negedge PCLK);
         if (c < lat) begin
            check("busy.cmd_ready", cmd_ready, 0);
            check("busy.rsp_valid", rsp_valid, 0);
            check("busy.psel",      PSELx,     1);
            check("busy.penable",   PENABLE,   (c > 1) ? 1 : 0);
            check("busy.paddr",     PADDR,     addr);
            check("busy.pwrite",    PWRITE,    wr);
            check("busy.pwdata",    PWDATA,    wdata);
         end else begin
            check("rsp.valid",     rsp_valid, 1);
            check("rsp.err",       rsp_err,   ok ? 0 : 1);
            check("rsp.rdata",     rsp_rdata, exp_rd);
            check("rsp.cmd_ready", cmd_ready, 1);
            check("rsp.psel",      PSELx,     0);
            check("rsp.penable",   PENABLE,   0);
            check("rsp.paddr",     PADDR,     addr);
         end
         PRDATA = 8'($urandom);
         PREADY = 1'($urandom);
         if (c >= 2 && c < lat) begin
            PREADY = ((c - 1) == waits + 1);
            if (PREADY && !wr) PRDATA = mem[addr];
         end
         if (c == lat) begin
            cmd_valid = 1'b0;
         end else if (!hold) begin
            cmd_valid = 1'($urandom);
            cmd_write = 1'($urandom);
            cmd_addr  = 4'($urandom);
            cmd_wdata = 8'($urandom);
         end
      end
      last_addr = addr;
      if (ok && wr) mem[addr] = wdata;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      last_addr = 4'h0;
      PRESET    = 1'b1;
      rand_inputs();

      // Reset held for 3 cycles with random inputs.
      repeat (3) begin
         @(negedge PCLK);
         check_reset_vals("reset");
         rand_inputs();
      end
      PRESET    = 1'b0;
      cmd_valid = 1'b0;
      @(negedge PCLK);
      check("post_reset.cmd_ready", cmd_ready, 1);
      check("post_reset.psel",      PSELx,     0);

      // Directed: zero-wait write, 2-wait read, timeout, ready on the last allowed cycle.
      xfer(1'b1, 4'h3, 8'hA5, 0, 1'b0);
      idle(1);
      mem[3] = 8'h5C;
      xfer(1'b0, 4'h3, 8'($urandom), 2, 1'b0);
      idle(1);
      xfer(1'b1, 4'h2, 8'h33, TO, 1'b0);
      idle(1);
      xfer(1'b0, 4'h2, 8'($urandom), TO - 1, 1'b0);

      // Back-to-back with cmd_valid held: second command accepted in the response cycle.
      xfer(1'b1, 4'h1, 8'h11, 0, 1'b1);
      xfer(1'b0, 4'h1, 8'($urandom), 0, 1'b1);
      idle(1);

      // Randomized traffic, including waits beyond the timeout budget.
      for (int n = 0; n < 40; n++) begin
         xfer(1'($urandom), 4'($urandom), 8'($urandom),
              int'($urandom_range(0, TO + 1)), 1'($urandom));
         idle(int'($urandom_range(0, 2)));
      end

      // Reset during ACCESS with a wait state pending.
      idle(1);
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 4'h7;
      cmd_wdata = 8'h3C;
      PREADY    = 1'b0;
      @(posedge PCLK);
      @(negedge PCLK);
      check("rst_mid.setup_psel", PSELx, 1);
      cmd_valid = 1'b0;
      PREADY    = 1'b1;
      @(negedge PCLK);
      check("rst_mid.access_penable", PENABLE, 1);
      PREADY = 1'b0;
      PRESET = 1'b1;
      @(negedge PCLK);
      check_reset_vals("rst_mid");
      PRESET = 1'b0;
      @(negedge PCLK);
      check("rst_mid.release_cmd_ready", cmd_ready, 1);
      check("rst_mid.release_rsp",       rsp_valid, 0);
      last_addr = 4'h0;
      idle(2);
      xfer(1'b0, 4'h7, 8'($urandom), 1, 1'b0);
      idle(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
